// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit:
//   - RV32I base opcode values
//   - FSM state type
//   - one-hot instruction class indices
//   - encodings of the pc_sel / wb_sel / alu_a_sel / alu_b_sel / imm_sel / trap_cause outputs
package multicycle_control_unit_pkg;

  // Base opcodes recognised by the sequencer
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } state_t;

  // Bit positions inside the one-hot class vector
  localparam int unsigned CLS_LUI    = 0;
  localparam int unsigned CLS_AUIPC  = 1;
  localparam int unsigned CLS_JAL    = 2;
  localparam int unsigned CLS_JALR   = 3;
  localparam int unsigned CLS_BRANCH = 4;
  localparam int unsigned CLS_LOAD   = 5;
  localparam int unsigned CLS_STORE  = 6;
  localparam int unsigned CLS_OPIMM  = 7;
  localparam int unsigned CLS_OP     = 8;
  localparam int unsigned CLS_FENCE  = 9;
  localparam int unsigned CLS_SYSTEM = 10;
  localparam int unsigned CLS_W      = 11;

  typedef logic [CLS_W-1:0] cls_t;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4 = 2'd0,
    PC_SEL_REL   = 2'd1,
    PC_SEL_JALR  = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_sel_e;

  typedef enum logic {
    ALU_B_RS2 = 1'b0,
    ALU_B_IMM = 1'b1
  } alu_b_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_U = 3'd2,
    IMM_B = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_ECALL   = 2'd2,
    TC_TIMEOUT = 2'd3
  } trap_cause_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the control unit and its surroundings (decoder, comparator,
// instruction/data memories, datapath enables and muxes).
//   master : the control unit (consumes decoder/memory status, drives controls)
//   slave  : the environment (drives decoder/memory status, consumes controls)
// Inputs : opcode_i[7], funct3_i[3], rd_i[5], branch_cond_i, imem_ready_i, dmem_ready_i
// Outputs: imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o[2], rf_we_o,
//          wb_sel_o[2], alu_a_sel_o[2], alu_b_sel_o, imm_sel_o[3], retired_o,
//          halted_o, trap_cause_o[2]
interface multicycle_control_unit_if;

  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [4:0] rd_i;
  logic       branch_cond_i;
  logic       imem_ready_i;
  logic       dmem_ready_i;

  logic       imem_req_o;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       ir_we_o;
  logic       pc_we_o;
  logic [1:0] pc_sel_o;
  logic       rf_we_o;
  logic [1:0] wb_sel_o;
  logic [1:0] alu_a_sel_o;
  logic       alu_b_sel_o;
  logic [2:0] imm_sel_o;
  logic       retired_o;
  logic       halted_o;
  logic [1:0] trap_cause_o;

  modport master (
    input  opcode_i, funct3_i, rd_i, branch_cond_i, imem_ready_i, dmem_ready_i,
    output imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o,
           wb_sel_o, alu_a_sel_o, alu_b_sel_o, imm_sel_o, retired_o, halted_o,
           trap_cause_o
  );

  modport slave (
    output opcode_i, funct3_i, rd_i, branch_cond_i, imem_ready_i, dmem_ready_i,
    input  imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o,
           wb_sel_o, alu_a_sel_o, alu_b_sel_o, imm_sel_o, retired_o, halted_o,
           trap_cause_o
  );

endinterface

// File: rtl/multicycle_control_unit_classify.sv
// control_opcode_classify: purely combinational opcode classifier.
//   i_opcode : 7-bit base opcode
//   o_class  : one-hot instruction class (all zero for an unknown opcode)
//   o_legal  : opcode is one the sequencer knows (SYSTEM included; it traps separately)
module control_opcode_classify
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_t       o_class,
  output logic       o_legal
);

  always_comb begin
    o_class = '0;
    unique case (i_opcode)
      OPC_LUI:    o_class[CLS_LUI]    = 1'b1;
      OPC_AUIPC:  o_class[CLS_AUIPC]  = 1'b1;
      OPC_JAL:    o_class[CLS_JAL]    = 1'b1;
      OPC_JALR:   o_class[CLS_JALR]   = 1'b1;
      OPC_BRANCH: o_class[CLS_BRANCH] = 1'b1;
      OPC_LOAD:   o_class[CLS_LOAD]   = 1'b1;
      OPC_STORE:  o_class[CLS_STORE]  = 1'b1;
      OPC_OPIMM:  o_class[CLS_OPIMM]  = 1'b1;
      OPC_OP:     o_class[CLS_OP]     = 1'b1;
      OPC_FENCE:  o_class[CLS_FENCE]  = 1'b1;
      OPC_SYSTEM: o_class[CLS_SYSTEM] = 1'b1;
      default:    o_class             = '0;
    endcase
    o_legal = |o_class;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
// Halts in TRAP on an illegal opcode, ECALL/EBREAK or a memory timeout;
// only rst_ni leaves TRAP.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : decoder/memory inputs and all control outputs (master side)
// Parameters:
//   TIMEOUT_CYCLES : wait cycles a memory request may spend without ready before trapping
//   TIMEOUT_W      : width of the wait counter
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  multicycle_control_unit_if.master  bus
);

  // The wait counter holds the number of earlier no-ready cycles, so the
  // TIMEOUT_CYCLES-th waiting cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  cls_t                 r_class;
  logic                 r_taken;
  logic [TIMEOUT_W-1:0] r_wait;
  logic [1:0]           r_cause;

  state_t               w_state_next;
  logic [1:0]           w_cause_next;
  cls_t                 w_dec_class;
  logic                 w_dec_legal;
  logic                 w_waiting;
  logic                 w_wait_hit;
  logic                 w_sel_active;
  logic                 w_unused_funct3;

  // funct3 is carried on the bus for the datapath; the sequencer does not need it
  assign w_unused_funct3 = ^bus.funct3_i;

  control_opcode_classify u_classify (
    .i_opcode (bus.opcode_i),
    .o_class  (w_dec_class),
    .o_legal  (w_dec_legal)
  );

  assign w_waiting  = ((r_state == ST_FETCH) && !bus.imem_ready_i) ||
                      ((r_state == ST_MEM)   && !bus.dmem_ready_i);
  assign w_wait_hit = (r_wait == WAIT_LIMIT);

  // State register plus the registers latched along the way
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_class <= '0;
      r_taken <= 1'b0;
      r_wait  <= '0;
      r_cause <= TC_NONE;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
      end
      if (r_state == ST_EXECUTE) begin
        r_taken <= bus.branch_cond_i;
      end
      // Counter only advances while staying in the same waiting state;
      // ready, a timeout trap or any other transition clears it.
      if (w_waiting && (w_state_next == r_state)) begin
        r_wait <= r_wait + TIMEOUT_W'(1);
      end else begin
        r_wait <= '0;
      end
      if ((w_state_next == ST_TRAP) && (r_state != ST_TRAP)) begin
        r_cause <= w_cause_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cause_next = TC_NONE;
    unique case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ready_i) begin
          w_state_next = ST_DECODE;
        end else if (w_wait_hit) begin
          w_state_next = ST_TRAP;
          w_cause_next = TC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!w_dec_legal) begin
          w_state_next = ST_TRAP;
          w_cause_next = TC_ILLEGAL;
        end else if (w_dec_class[CLS_SYSTEM]) begin
          w_state_next = ST_TRAP;
          w_cause_next = TC_ECALL;
        end else if (w_dec_class[CLS_FENCE]) begin
          w_state_next = ST_WRITEBACK;
        end else begin
          w_state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (r_class[CLS_LOAD] || r_class[CLS_STORE]) begin
          w_state_next = ST_MEM;
        end else begin
          w_state_next = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ready_i) begin
          w_state_next = ST_WRITEBACK;
        end else if (w_wait_hit) begin
          w_state_next = ST_TRAP;
          w_cause_next = TC_TIMEOUT;
        end
      end
      ST_WRITEBACK: w_state_next = ST_FETCH;
      ST_TRAP:      w_state_next = ST_TRAP;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // The ALU operand/immediate selects stay valid from EXECUTE through
  // WRITEBACK so the address (MEM) and ALU result (WRITEBACK) remain stable.
  assign w_sel_active = (r_state == ST_EXECUTE) || (r_state == ST_MEM) ||
                        (r_state == ST_WRITEBACK);

  // Output decode: registered state and latched class only
  always_comb begin
    bus.imem_req_o   = 1'b0;
    bus.dmem_req_o   = 1'b0;
    bus.dmem_we_o    = 1'b0;
    bus.ir_we_o      = 1'b0;
    bus.pc_we_o      = 1'b0;
    bus.pc_sel_o     = PC_SEL_PLUS4;
    bus.rf_we_o      = 1'b0;
    bus.wb_sel_o     = WB_SEL_ALU;
    bus.alu_a_sel_o  = ALU_A_RS1;
    bus.alu_b_sel_o  = ALU_B_RS2;
    bus.imm_sel_o    = IMM_I;
    bus.retired_o    = 1'b0;
    bus.halted_o     = 1'b0;
    bus.trap_cause_o = TC_NONE;

    if (w_sel_active) begin
      if (r_class[CLS_LUI]) begin
        bus.alu_a_sel_o = ALU_A_ZERO;
      end else if (r_class[CLS_AUIPC] || r_class[CLS_JAL]) begin
        bus.alu_a_sel_o = ALU_A_PC;
      end
      bus.alu_b_sel_o = r_class[CLS_OP] ? ALU_B_RS2 : ALU_B_IMM;
      if (r_class[CLS_STORE]) begin
        bus.imm_sel_o = IMM_S;
      end else if (r_class[CLS_LUI] || r_class[CLS_AUIPC]) begin
        bus.imm_sel_o = IMM_U;
      end else if (r_class[CLS_BRANCH]) begin
        bus.imm_sel_o = IMM_B;
      end else if (r_class[CLS_JAL]) begin
        bus.imm_sel_o = IMM_J;
      end
    end

    unique case (r_state)
      ST_FETCH: begin
        bus.imem_req_o = 1'b1;
        bus.ir_we_o    = bus.imem_ready_i;
      end
      ST_MEM: begin
        bus.dmem_req_o = 1'b1;
        bus.dmem_we_o  = r_class[CLS_STORE];
      end
      ST_WRITEBACK: begin
        bus.pc_we_o   = 1'b1;
        bus.retired_o = 1'b1;
        if (r_class[CLS_JAL] || (r_class[CLS_BRANCH] && r_taken)) begin
          bus.pc_sel_o = PC_SEL_REL;
        end else if (r_class[CLS_JALR]) begin
          bus.pc_sel_o = PC_SEL_JALR;
        end
        bus.rf_we_o = (r_class[CLS_LUI]  || r_class[CLS_AUIPC] || r_class[CLS_JAL] ||
                       r_class[CLS_JALR] || r_class[CLS_LOAD]  || r_class[CLS_OPIMM] ||
                       r_class[CLS_OP]) && (bus.rd_i != 5'd0);
        if (r_class[CLS_LOAD]) begin
          bus.wb_sel_o = WB_SEL_LOAD;
        end else if (r_class[CLS_JAL] || r_class[CLS_JALR]) begin
          bus.wb_sel_o = WB_SEL_PC4;
        end
      end
      ST_TRAP: begin
        bus.halted_o     = 1'b1;
        bus.trap_cause_o = r_cause;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int unsigned TO = 255;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP,
                K_FENCE, K_SYS, K_ILL} kind_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_a;
    logic       alu_b;
    logic [2:0] imm;
    logic       retired;
    logic       halted;
    logic [1:0] cause;
  } outv_t;

  typedef struct {
    logic       irdy;
    logic       drdy;
    logic       cond;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    outv_t      exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  step_t       sched[$];
  outv_t       exp_o;
  bit          exp_valid = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [4:0]  cur_rd;

  // Monitor results
  int unsigned cyc = 0;
  int unsigned ir_cyc = 0;
  int unsigned last_lat = 0;
  int unsigned n_retired = 0;
  int unsigned n_dreq = 0;
  outv_t       last_wb;
  logic        last_dwe = 1'b0;

  function automatic outv_t dut_out();
    outv_t o;
    o.imem_req = bus.imem_req_o;
    o.dmem_req = bus.dmem_req_o;
    o.dmem_we  = bus.dmem_we_o;
    o.ir_we    = bus.ir_we_o;
    o.pc_we    = bus.pc_we_o;
    o.pc_sel   = bus.pc_sel_o;
    o.rf_we    = bus.rf_we_o;
    o.wb_sel   = bus.wb_sel_o;
    o.alu_a    = bus.alu_a_sel_o;
    o.alu_b    = bus.alu_b_sel_o;
    o.imm      = bus.imm_sel_o;
    o.retired  = bus.retired_o;
    o.halted   = bus.halted_o;
    o.cause    = bus.trap_cause_o;
    return o;
  endfunction

  function automatic string fmt(outv_t o);
    return $sformatf("ireq=%0b dreq=%0b dwe=%0b irwe=%0b pcwe=%0b pcsel=%0d rfwe=%0b wbsel=%0d a=%0d b=%0b imm=%0d ret=%0b halt=%0b cause=%0d",
                     o.imem_req, o.dmem_req, o.dmem_we, o.ir_we, o.pc_we, o.pc_sel, o.rf_we,
                     o.wb_sel, o.alu_a, o.alu_b, o.imm, o.retired, o.halted, o.cause);
  endfunction

  // Per-cycle compare against the model plus simple activity monitors
  always @(negedge clk) begin
    cyc++;
    if (exp_valid) begin
      n_checks++;
      if (dut_out() === exp_o) n_pass++;
      else $display("FAIL cycle_%0d outputs: got [%s] expected [%s]", cyc, fmt(dut_out()), fmt(exp_o));
    end
    if (bus.ir_we_o === 1'b1) ir_cyc = cyc;
    if (bus.retired_o === 1'b1) begin
      last_lat = cyc - ir_cyc + 1;
      n_retired++;
      last_wb = dut_out();
    end
    if (bus.dmem_req_o === 1'b1) begin
      n_dreq++;
      last_dwe = bus.dmem_we_o;
    end
  end

  task automatic check_int(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic kind_t kind_of(logic [6:0] op);
    case (op)
      OP_LUI:    return K_LUI;
      OP_AUIPC:  return K_AUIPC;
      OP_JAL:    return K_JAL;
      OP_JALR:   return K_JALR;
      OP_BRANCH: return K_BR;
      OP_LOAD:   return K_LD;
      OP_STORE:  return K_ST;
      OP_OPIMM:  return K_OPI;
      OP_OP:     return K_OP;
      OP_FENCE:  return K_FENCE;
      OP_SYSTEM: return K_SYS;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic void push(logic ir, logic dr, logic c, outv_t o);
    step_t s;
    s.irdy = ir; s.drdy = dr; s.cond = c;
    s.op = cur_op; s.f3 = cur_f3; s.rd = cur_rd;
    s.exp = o;
    sched.push_back(s);
  endfunction

  function automatic void push_trap(logic [1:0] cause);
    outv_t o = '0;
    o.halted = 1'b1;
    o.cause  = cause;
    for (int i = 0; i < 6; i++) push(rb(), rb(), rb(), o);
  endfunction

  // Expected cycle-by-cycle timeline of one instruction, starting at its fetch.
  // iw/dw: wait cycles before imem/dmem ready; dw >= TO means dmem never answers.
  function automatic void build(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic cond,
                                int unsigned iw, int unsigned dw);
    kind_t k = kind_of(op);
    outv_t o;
    outv_t sel;
    bit    writes;
    cur_op = op; cur_f3 = f3; cur_rd = rd;
    for (int unsigned i = 0; i < iw; i++) begin
      o = '0; o.imem_req = 1'b1;
      push(1'b0, rb(), rb(), o);
    end
    o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1;
    push(1'b1, rb(), rb(), o);
    push(rb(), rb(), rb(), '0);
    if (k == K_SYS || k == K_ILL) begin
      push_trap(k == K_SYS ? 2'd2 : 2'd1);
      return;
    end
    sel = '0;
    sel.alu_a = (k == K_LUI) ? 2'd2 : ((k == K_AUIPC || k == K_JAL) ? 2'd1 : 2'd0);
    sel.alu_b = (k != K_OP);
    sel.imm   = (k == K_ST) ? 3'd1 : (k == K_LUI || k == K_AUIPC) ? 3'd2 :
                (k == K_BR) ? 3'd3 : (k == K_JAL) ? 3'd4 : 3'd0;
    if (k != K_FENCE) push(rb(), rb(), cond, sel);
    if (k == K_LD || k == K_ST) begin
      o = sel; o.dmem_req = 1'b1; o.dmem_we = (k == K_ST);
      for (int unsigned i = 0; i < dw && i < TO; i++) push(rb(), 1'b0, rb(), o);
      if (dw >= TO) begin
        push_trap(2'd3);
        return;
      end
      push(rb(), 1'b1, rb(), o);
    end
    writes = (k == K_LUI || k == K_AUIPC || k == K_JAL || k == K_JALR ||
              k == K_LD || k == K_OPI || k == K_OP);
    o = sel;
    o.pc_we   = 1'b1;
    o.retired = 1'b1;
    o.pc_sel  = (k == K_JAL || (k == K_BR && cond)) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    o.rf_we   = writes && (rd != 5'd0);
    o.wb_sel  = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
    push(rb(), rb(), rb(), o);
  endfunction

  // Plays up to n scheduled steps (all if n < 0), one per clock
  task automatic play(input int n);
    step_t s;
    int    k = 0;
    while (sched.size() > 0 && (n < 0 || k < n)) begin
      s = sched.pop_front();
      @(posedge clk); #1;
      bus.imem_ready_i  = s.irdy;
      bus.dmem_ready_i  = s.drdy;
      bus.branch_cond_i = s.cond;
      bus.opcode_i      = s.op;
      bus.funct3_i      = s.f3;
      bus.rd_i          = s.rd;
      exp_o     = s.exp;
      exp_valid = 1'b1;
      k++;
    end
    @(negedge clk); #1;
    exp_valid = 1'b0;
  endtask

  // Async reset, held for two edges with readies asserted, then the IDLE cycle
  task automatic do_reset();
    outv_t z = '0;
    sched.delete();
    rst_ni = 1'b0;
    #1;
    check_int("async_reset_outputs", 32'(dut_out()), 32'(z));
    exp_o = '0;
    exp_valid = 1'b1;
    bus.imem_ready_i = 1'b1;
    bus.dmem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    bus.imem_ready_i = 1'b1;
    bus.dmem_ready_i = rb();
    @(negedge clk); #1;
    exp_valid = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [31:0] w, input logic cond,
                          input int unsigned iw, input int unsigned dw,
                          input int unsigned exp_steps);
    build(w[6:0], w[14:12], w[11:7], cond, iw, dw);
    check_int({name, "_model_steps"}, sched.size(), exp_steps);
    play(-1);
  endtask

  logic [6:0]  legal_ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                 OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};

  initial begin
    int unsigned r0;
    int unsigned d0;
    logic [6:0]  op;
    logic [4:0]  rd;
    kind_t       k;

    bus.opcode_i = '0; bus.funct3_i = '0; bus.rd_i = '0;
    bus.branch_cond_i = 1'b0; bus.imem_ready_i = 1'b0; bus.dmem_ready_i = 1'b0;
    #2;
    do_reset();

    // ADDI x1, x0, 5 with two imem wait cycles
    r0 = n_retired;
    run_word("addi", 32'h00500093, 1'b0, 2, 0, 6);
    check_int("addi_latency", last_lat, 4);
    check_int("addi_retired_once", n_retired - r0, 1);
    check_int("addi_rf_we", 32'(last_wb.rf_we), 1);
    check_int("addi_alu_b_sel", 32'(last_wb.alu_b), 1);
    check_int("addi_pc_sel", 32'(last_wb.pc_sel), 0);

    // BEQ taken then not taken
    run_word("beq_taken", 32'h00208463, 1'b1, 0, 0, 4);
    check_int("beq_taken_pc_sel", 32'(last_wb.pc_sel), 1);
    check_int("beq_taken_latency", last_lat, 4);
    run_word("beq_not_taken", 32'h00208463, 1'b0, 0, 0, 4);
    check_int("beq_not_taken_pc_sel", 32'(last_wb.pc_sel), 0);
    check_int("beq_rf_we", 32'(last_wb.rf_we), 0);

    // LW x5 then SW
    run_word("lw", 32'h0000A283, 1'b0, 0, 0, 5);
    check_int("lw_dmem_we", 32'(last_dwe), 0);
    check_int("lw_wb_sel", 32'(last_wb.wb_sel), 1);
    check_int("lw_latency", last_lat, 5);
    run_word("sw", 32'h0050A023, 1'b0, 0, 0, 5);
    check_int("sw_dmem_we", 32'(last_dwe), 1);
    check_int("sw_rf_we", 32'(last_wb.rf_we), 0);
    check_int("sw_latency", last_lat, 5);

    // JAL x0, JALR x1
    run_word("jal_x0", 32'h0000006F, 1'b0, 1, 0, 5);
    check_int("jal_pc_sel", 32'(last_wb.pc_sel), 1);
    check_int("jal_x0_rf_we", 32'(last_wb.rf_we), 0);
    run_word("jalr_x1", 32'h000100E7, 1'b0, 0, 0, 4);
    check_int("jalr_pc_sel", 32'(last_wb.pc_sel), 2);
    check_int("jalr_wb_sel", 32'(last_wb.wb_sel), 2);

    // FENCE retires as a NOP
    run_word("fence", 32'h0000000F, 1'b0, 0, 0, 3);

    // Ready on the very last allowed wait cycle still completes
    d0 = n_dreq;
    r0 = n_retired;
    run_word("lw_ready_at_limit", 32'h0000A283, 1'b0, 0, TO - 1, 4 + TO);
    check_int("limit_dreq_cycles", n_dreq - d0, TO);
    check_int("limit_retired", n_retired - r0, 1);

    // Illegal opcode
    run_word("illegal", 32'h0000007F, 1'b0, 0, 0, 8);
    check_int("illegal_cause", 32'(bus.trap_cause_o), 1);
    check_int("illegal_halted", 32'(bus.halted_o), 1);
    do_reset();

    // ECALL
    run_word("ecall", 32'h00000073, 1'b0, 0, 0, 8);
    check_int("ecall_cause", 32'(bus.trap_cause_o), 2);
    do_reset();

    // Data memory never ready
    d0 = n_dreq;
    run_word("lw_timeout", 32'h0000A283, 1'b0, 0, 1000, 3 + TO + 6);
    check_int("timeout_dreq_cycles", n_dreq - d0, TO);
    check_int("timeout_cause", 32'(bus.trap_cause_o), 3);
    check_int("timeout_halted", 32'(bus.halted_o), 1);
    do_reset();

    // Reset asserted mid-MEM
    build(OP_LOAD, 3'd2, 5'd5, 1'b0, 0, 6);
    play(5);
    check_int("mid_mem_req_before_reset", 32'(bus.dmem_req_o), 1);
    r0 = n_retired;
    do_reset();
    check_int("mid_mem_no_retire", n_retired - r0, 0);
    run_word("addi_after_reset", 32'h00500093, 1'b0, 0, 0, 4);

    // Randomised instruction stream
    for (int n = 0; n < 250; n++) begin
      r0 = $urandom_range(0, 99);
      if (r0 < 3) begin
        do op = 7'($urandom); while (kind_of(op) != K_ILL);
      end else if (r0 < 5) begin
        op = OP_SYSTEM;
      end else if (r0 < 10) begin
        op = OP_FENCE;
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      k = kind_of(op);
      build(op, 3'($urandom), rd, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      play(-1);
      if (k == K_SYS || k == K_ILL) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
